// File: rtl/escritor_registros.sv
// Register-file write buffer: queued writes drain one per cycle in FIFO order, visible one cycle after acceptance.
// Backpressure: in_ready drops while PROF writes are pending; hold stalls draining and pending entries remain forwardable.
module escritor_registros #(
    parameter int S_AD   = 5,
    parameter int S_DATA = 32,
    parameter int PROF   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [S_AD-1:0]         in_ad,
    input  logic [S_DATA-1:0]       in_data,
    input  logic                    hold,
    output logic                    WE,
    output logic [S_AD-1:0]         AWR,
    output logic [S_DATA-1:0]       DataIn,
    input  logic [S_AD-1:0]         q_ad1,
    input  logic [S_AD-1:0]         q_ad2,
    output logic                    hit1,
    output logic                    hit2,
    output logic [S_DATA-1:0]       fwd1,
    output logic [S_DATA-1:0]       fwd2,
    output logic [$clog2(PROF):0]   ocupacion
);

    localparam int PTR_W = $clog2(PROF);
    localparam int CNT_W = PTR_W + 1;

    logic [S_AD-1:0]   ad_mem   [PROF];
    logic [S_DATA-1:0] data_mem [PROF];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;
    logic              empty;

    assign empty    = (ocupacion == '0);
    assign in_ready = (ocupacion < CNT_W'(PROF));
    // rst gating keeps a discarded entry from landing in the register file on the reset edge
    assign WE       = !empty && !hold && !rst;
    assign AWR      = empty ? '0 : ad_mem[rd_ptr];
    assign DataIn   = empty ? '0 : data_mem[rd_ptr];
    assign push     = in_valid && in_ready && (in_ad != '0) && !rst;
    assign pop      = WE;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ocupacion <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   ocupacion <= ocupacion + 1'b1;
                2'b01:   ocupacion <= ocupacion - 1'b1;
                default: ocupacion <= ocupacion;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ad_mem[wr_ptr]   <= in_ad;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Walk oldest to newest so the last match is the newest pending value
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int k = 0; k < PROF; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < ocupacion) begin
                if (q_ad1 != '0 && ad_mem[idx] == q_ad1) begin
                    hit1 = 1'b1;
                    fwd1 = data_mem[idx];
                end
                if (q_ad2 != '0 && ad_mem[idx] == q_ad2) begin
                    hit2 = 1'b1;
                    fwd2 = data_mem[idx];
                end
            end
        end
    end

endmodule
